// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with tear-free value updates.
// All outputs are registered and are computed from the state being entered.
module seg_scan_ctrl #(
  parameter int ON_TICKS    = 100000,
  parameter int BLANK_TICKS = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        dp_n,
  output logic        pending,
  output logic        frame_start
);

  localparam int TMAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_TICKS > 0);

  typedef enum logic [1:0] {OFF, ON, BLANK} state_t;

  state_t        state, state_nx;
  logic [1:0]    slot, slot_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [15:0]   display, display_nx, shadow, shadow_nx;
  logic [3:0]    dp_disp, dp_disp_nx, dp_shadow, dp_shadow_nx;
  logic          pending_nx, enter0, promote;
  logic [3:0]    an_nx, digit_nx;
  logic          dp_n_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= OFF;
      slot        <= 2'd0;
      tick        <= '0;
      display     <= 16'h0;
      dp_disp     <= 4'h0;
      shadow      <= 16'h0;
      dp_shadow   <= 4'h0;
      pending     <= 1'b0;
      an          <= 4'b1111;
      digit       <= 4'h0;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      slot        <= slot_nx;
      tick        <= tick_nx;
      display     <= display_nx;
      dp_disp     <= dp_disp_nx;
      shadow      <= shadow_nx;
      dp_shadow   <= dp_shadow_nx;
      pending     <= pending_nx;
      an          <= an_nx;
      digit       <= digit_nx;
      dp_n        <= dp_n_nx;
      frame_start <= enter0;
    end
  end

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    tick_nx  = tick;
    if (!en) begin
      state_nx = OFF;
      slot_nx  = 2'd0;
      tick_nx  = '0;
    end else begin
      case (state)
        OFF: begin
          state_nx = ON;
          slot_nx  = 2'd0;
          tick_nx  = '0;
        end
        ON: begin
          if (tick == ON_LAST) begin
            tick_nx = '0;
            if (HAS_BLANK) begin
              state_nx = BLANK;
            end else begin
              slot_nx = slot + 2'd1;
            end
          end else begin
            tick_nx = tick + 1'b1;
          end
        end
        BLANK: begin
          if (tick == BLANK_LAST) begin
            state_nx = ON;
            slot_nx  = slot + 2'd1;
            tick_nx  = '0;
          end else begin
            tick_nx = tick + 1'b1;
          end
        end
        default: begin
          state_nx = OFF;
          slot_nx  = 2'd0;
          tick_nx  = '0;
        end
      endcase
    end

    // Display may only change when a frame begins or while dark, so no frame ever tears.
    enter0  = (state_nx == ON) && (slot_nx == 2'd0) && !((state == ON) && (slot == 2'd0));
    promote = enter0 || (state_nx == OFF);

    display_nx   = display;
    dp_disp_nx   = dp_disp;
    shadow_nx    = shadow;
    dp_shadow_nx = dp_shadow;
    pending_nx   = pending;
    if (load) begin
      shadow_nx    = value;
      dp_shadow_nx = dp_in;
      if (promote) begin
        display_nx = value;
        dp_disp_nx = dp_in;
        pending_nx = 1'b0;
      end else begin
        pending_nx = 1'b1;
      end
    end else if (promote && pending) begin
      display_nx = shadow;
      dp_disp_nx = dp_shadow;
      pending_nx = 1'b0;
    end

    an_nx    = 4'b1111;
    dp_n_nx  = 1'b1;
    digit_nx = 4'h0;
    if (state_nx != OFF) begin
      digit_nx = display_nx[{slot_nx, 2'b00} +: 4];
    end
    if ((state_nx == ON) && !blank_mask[slot_nx]) begin
      an_nx   = ~(4'b0001 << slot_nx);
      dp_n_nx = ~dp_disp_nx[slot_nx];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl: a blanking build and a no-blank build run side by side
// against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int ONT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0, mask = 4'h0;

  logic [3:0] an0, an1, dig0, dig1;
  logic       dpn0, dpn1, pend0, pend1, fs0, fs1;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.ON_TICKS(ONT), .BLANK_TICKS(2)) dut0 (
    .clk(clk), .reset(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .blank_mask(mask), .an(an0), .digit(dig0), .dp_n(dpn0), .pending(pend0), .frame_start(fs0)
  );

  seg_scan_ctrl #(.ON_TICKS(ONT), .BLANK_TICKS(0)) dut1 (
    .clk(clk), .reset(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .blank_mask(mask), .an(an1), .digit(dig1), .dp_n(dpn1), .pending(pend1), .frame_start(fs1)
  );

  // Reference model: position inside the scan is derived from cycles since scanning began.
  int          per[2] = '{24, 16};
  int          slen[2] = '{6, 4};
  bit          m_act[2];
  int          m_t[2];
  logic [15:0] m_disp[2], m_sh[2];
  logic [3:0]  m_dpd[2], m_dsh[2];
  bit          m_pend[2], e_fs[2], e_on[2];
  int          e_slot[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input int d);
    int  pos;
    bit  promote;
    if (rst) begin
      m_act[d] = 0; m_t[d] = 0; m_disp[d] = 0; m_sh[d] = 0; m_dpd[d] = 0; m_dsh[d] = 0;
      m_pend[d] = 0; e_fs[d] = 0; e_on[d] = 0; e_slot[d] = 0;
    end else begin
      if (!en) m_act[d] = 0;
      else if (!m_act[d]) begin m_act[d] = 1; m_t[d] = 0; end
      else m_t[d]++;
      pos       = m_t[d] % per[d];
      e_slot[d] = m_act[d] ? pos / slen[d] : 0;
      e_on[d]   = m_act[d] && ((pos % slen[d]) < ONT);
      e_fs[d]   = m_act[d] && (pos == 0);
      promote   = e_fs[d] || !m_act[d];
      if (load) begin
        m_sh[d] = value; m_dsh[d] = dp_in;
        if (promote) begin m_disp[d] = value; m_dpd[d] = dp_in; m_pend[d] = 0; end
        else m_pend[d] = 1;
      end else if (promote && m_pend[d]) begin
        m_disp[d] = m_sh[d]; m_dpd[d] = m_dsh[d]; m_pend[d] = 0;
      end
    end
  endtask

  task automatic compare(input int d);
    logic [3:0] ea, ed;
    logic       edp;
    int         s;
    s   = e_slot[d];
    ea  = 4'b1111;
    edp = 1'b1;
    if (e_on[d] && !mask[s]) begin
      ea  = ~(4'b0001 << s);
      edp = ~m_dpd[d][s];
    end
    ed = m_disp[d][4*s +: 4];
    check_val(d ? "an_nb" : "an", d ? an1 : an0, ea);
    check_val(d ? "dpn_nb" : "dpn", d ? dpn1 : dpn0, edp);
    check_val(d ? "fs_nb" : "fs", d ? fs1 : fs0, e_fs[d]);
    check_val(d ? "pend_nb" : "pend", d ? pend1 : pend0, m_pend[d]);
    if (e_on[d]) check_val(d ? "dig_nb" : "dig", d ? dig1 : dig0, ed);
    else if (!m_act[d]) check_val(d ? "dig_off_nb" : "dig_off", d ? dig1 : dig0, 4'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      model_edge(d);
      compare(d);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    check_val("rst_an", an0, 4'b1111);
    check_val("rst_dpn", dpn0, 1'b1);
    check_val("rst_dig", dig0, 4'h0);

    // First frame after enabling with a load issued while dark.
    rst = 1'b0; en = 1'b1; load = 1'b1; value = 16'h1234; dp_in = 4'b0101;
    step();
    load = 1'b0;
    check_val("first_an", an0, 4'b1110);
    check_val("first_fs", fs0, 1'b1);
    check_val("first_dig", dig0, 4'h4);
    repeat (9) step();

    // Load in the middle of slot 1 stays pending until the next frame.
    load = 1'b1; value = 16'hABCD; dp_in = 4'b1000;
    step();
    load = 1'b0;
    check_val("mid_pend", pend0, 1'b1);
    repeat (40) step();

    // Load on the edge that enters slot 0 goes straight to the display.
    while (((m_t[0] + 1) % per[0]) != 0) step();
    load = 1'b1; value = 16'h5555;
    step();
    load = 1'b0;
    check_val("edge_dig", dig0, 4'h5);
    check_val("edge_pend", pend0, 1'b0);
    check_val("edge_fs", fs0, 1'b1);

    // Slot 2 suppressed for two frames.
    mask = 4'b0100;
    repeat (50) step();
    mask = 4'b0000;

    // Drop enable in slot 2, restore, then reset in the middle of a blank phase.
    while ((m_t[0] % per[0]) != 13) step();
    en = 1'b0;
    step();
    check_val("endrop_an", an0, 4'b1111);
    repeat (3) step();
    en = 1'b1;
    step();
    check_val("enback_fs", fs0, 1'b1);
    while ((m_t[0] % per[0]) != 4) step();
    rst = 1'b1;
    step();
    check_val("rstmid_an", an0, 4'b1111);
    check_val("rstmid_dig", dig0, 4'h0);
    check_val("rstmid_pend", pend0, 1'b0);
    rst = 1'b0;
    step();
    check_val("rstmid_fs", fs0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 49) != 0);
      load  = ($urandom_range(0, 14) == 0);
      value = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 29) == 0) mask = 4'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
